dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the single-port data memory. It shares the memory between the pipeline memory-access stage (port P) and a loader/debug port (port D), which preloads or inspects data memory. Arbitration is round-robin; reads use a registered, one-cycle memory read. The block sits between the memory-access unit and the memory array. It owns the memory enable, write and address lines, and returns read data to whichever requester issued the read.

## Interface
- ADDR_W, 10, word-address width (1024 words)
- DATA_W, 32, data word width
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- p_req  in  1  pipeline request; held with fields stable until p_gnt
- p_we  in  1  pipeline write (1) / read (0)
- p_addr  in  ADDR_W  pipeline word address
- p_wdata  in  DATA_W  pipeline store data
- p_gnt  out  1  pipeline request accepted this cycle (combinational)
- p_stall  out  1  p_req & ~p_gnt; pipeline holds its stage
- p_rvalid  out  1  pipeline read data valid (registered)
- p_rdata  out  DATA_W  pipeline read data
- d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same widths and meanings for the loader port (no stall output)
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write this cycle
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en & ~mem_we

## Operation
- At most one grant per cycle. The granted port's we/addr/wdata drive the mem_* outputs combinationally, with mem_en = 1.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both requesting: the port not granted last wins. `last_gnt` is a 1-bit register, updated on every grant. Reset value is D, so P wins the first tie.
- Writes complete at the grant edge. No response is returned.
- Reads: the grant edge loads an in-flight register (`rd_pending`, `rd_owner`). In the next cycle the owner's rvalid = 1 and its rdata = mem_rdata.
- Back-to-back operation is fully pipelined: a new grant is allowed in the same cycle as the previous read's rvalid. Reads and writes to the same address in consecutive cycles follow memory order: a read after a write returns the new value.
- The rdata of the port not returning data holds its last value. rvalid is a single-cycle pulse.
- No request pending: mem_en = 0, mem_we = 0, mem_addr/mem_wdata = 0.
- Starvation bound: a continuously held request is granted within 2 cycles.

## Timing
- Reset values: p_gnt = d_gnt = 0 while rst is high. p_rvalid = d_rvalid = 0, p_rdata = d_rdata = 0, rd_pending = 0, last_gnt = D.
- Grant latency: 0 cycles when uncontested, at most 1 extra cycle when contested.
- Read latency: rvalid rises exactly 1 cycle after the gnt cycle.
- Reset asserted mid-read: the in-flight read is dropped and no rvalid is produced after reset is released.
- Requests with rst high are ignored and are not granted.
- A request that drops before its grant is simply lost. This is not an error; no state is kept.

## Structure
- Shared package/header: ADDR_W, DATA_W defaults and the port-ID encoding (PORT_P = 0, PORT_D = 1) used by `last_gnt` and `rd_owner`.
- Sub-module `rr_arb2`: a 2-requester round-robin picker holding `last_gnt`. Inputs are req[1:0] and an advance enable; output is a one-hot gnt.
- The top level contains the mux, the read-return register and the response demux.

## Test plan
- Reset: hold rst = 1 with p_req = d_req = 1 -> no gnt, mem_en = 0, all rvalid = 0. Release rst -> P granted first.
- P writes 0xDEADBEEF to address 5, then reads address 5 in the next cycle -> p_gnt is high both cycles, and p_rvalid pulses one cycle after the read grant with p_rdata = 0xDEADBEEF.
- Both ports request reads continuously (P address 1, D address 2) -> grants alternate P, D, P, D. Each rvalid goes to the correct port with the correct data, and p_stall is high on D cycles.
- D preloads addresses 0–3 with 0x10–0x13 while P is idle, then P reads addresses 0–3 back-to-back -> 4 consecutive p_rvalid pulses carrying 0x10..0x13.
- P read granted, then rst asserted in the following cycle -> no p_rvalid, and all outputs return to reset values immediately (asynchronously).
- P holds a request while D requests every cycle -> P is granted within 2 cycles and never starves across 100 cycles.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Purpose  : Shared widths and port-ID encoding for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  // Default geometry of the data memory: 1024 words of 32 bits.
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  // Requester identity, used both by the round-robin history and by the
  // read-return owner register.
  typedef enum logic {
    PORT_P = 1'b0,  // pipeline memory-access stage
    PORT_D = 1'b1   // loader / debug port
  } port_e;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-requester round-robin picker. A lone requester always wins;
//            on a tie the requester that was not granted last wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,   // bit 0 = P, bit 1 = D
  input  logic       adv,   // allow the history to move on this grant
  output logic [1:0] gnt    // one-hot grant
);

  port_e last_gnt_q;
  port_e last_gnt_d;

  // Pick the winner for this cycle from the request vector and history.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt_q == PORT_D) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember who won so the other side wins the next tie.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (adv && (gnt != 2'b00)) begin
      last_gnt_d = gnt[1] ? PORT_D : PORT_P;
    end
  end

  // History register; starts at D so the pipeline wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= PORT_D;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares a single-port data memory between the pipeline (P) and
//            the loader/debug port (D). Grants are combinational, reads
//            return one cycle after the grant to the port that issued them.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  // pipeline port
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  // loader / debug port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        req;
  logic [1:0]        gnt;

  logic              rd_pending_q, rd_pending_d;
  port_e             rd_owner_q,   rd_owner_d;
  logic [DATA_W-1:0] p_rdata_q,    p_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;

  // Requests seen while reset is high are never granted.
  assign req = {d_req, p_req} & {2{~rst}};

  // The memory accepts every grant immediately, so history always advances.
  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (req),
    .adv (1'b1),
    .gnt (gnt)
  );

  assign p_gnt   = gnt[0];
  assign d_gnt   = gnt[1];
  assign p_stall = p_req & ~p_gnt;

  // Steer the granted port onto the memory; idle bus is driven to zero.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_en    = 1'b1;
      mem_we    = p_we;
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
    end else if (gnt[1]) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Track the read in flight so its data goes back to the right port.
  always_comb begin
    rd_pending_d = mem_en & ~mem_we;
    rd_owner_d   = rd_owner_q;
    if (mem_en && !mem_we) begin
      rd_owner_d = gnt[1] ? PORT_D : PORT_P;
    end
  end

  // Response demux: the owner sees memory data, the other port holds.
  always_comb begin
    p_rvalid  = rd_pending_q & (rd_owner_q == PORT_P);
    d_rvalid  = rd_pending_q & (rd_owner_q == PORT_D);
    p_rdata   = p_rvalid ? mem_rdata : p_rdata_q;
    d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
    p_rdata_d = p_rdata;
    d_rdata_d = d_rdata;
  end

  // Read-return and held-data registers; reset drops any in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending_q <= 1'b0;
      rd_owner_q   <= PORT_P;
      p_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      p_rdata_q    <= p_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Scoreboard bench for dmem_arbiter. A reference model predicts
//            grants and read data; a separate monitor checks read returns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          p_req, p_we, p_gnt, p_stall, p_rvalid;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with a registered read.
  logic [DW-1:0] sim_mem [int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sim_mem[int'(mem_addr)] = mem_wdata;
      else        mem_rdata <= sim_mem.exists(int'(mem_addr)) ? sim_mem[int'(mem_addr)] : '0;
    end
  end

  // Reference state
  typedef struct {
    int            port;   // 0 = P, 1 = D
    logic [DW-1:0] data;
    int            due;    // cycle in which rvalid must be seen
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [int];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            model_last = 1;   // who won the last grant: 0 = P, 1 = D
  int            p_wait = 0;
  logic [DW-1:0] exp_prd = '0;
  logic [DW-1:0] exp_drd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: predict the grant and memory bus from the requests.
  always @(negedge clk) begin : sb
    bit ep, ed, we;
    int a;
    logic [DW-1:0] wd;
    if (rst) begin
      chk("rst_p_gnt",  p_gnt,  0);
      chk("rst_d_gnt",  d_gnt,  0);
      chk("rst_mem_en", mem_en, 0);
      model_last = 1;
      p_wait     = 0;
    end else begin
      ep = p_req && (!d_req || model_last == 1);
      ed = d_req && !ep;
      chk("p_gnt",   p_gnt,   ep);
      chk("d_gnt",   d_gnt,   ed);
      chk("p_stall", p_stall, p_req && !ep);
      chk("mem_en",  mem_en,  ep || ed);
      if (ep || ed) begin
        we = ep ? p_we : d_we;
        a  = ep ? int'(p_addr) : int'(d_addr);
        wd = ep ? p_wdata : d_wdata;
        chk("mem_we",    mem_we,         we);
        chk("mem_addr",  int'(mem_addr), a);
        chk("mem_wdata", mem_wdata,      wd);
        model_last = ed ? 1 : 0;
        if (we) ref_mem[a] = wd;
        else    exp_q.push_back('{port: (ed ? 1 : 0), data: ref_rd(a), due: cyc + 1});
      end else begin
        chk("idle_mem_we",    mem_we,    0);
        chk("idle_mem_addr",  mem_addr,  0);
        chk("idle_mem_wdata", mem_wdata, 0);
      end
      if (p_req && !p_gnt) p_wait++;
      else                 p_wait = 0;
      chk("p_wait_bound", (p_wait <= 1), 1);
    end
  end

  // Monitor: read returns must arrive exactly when due, at the right port.
  always @(negedge clk) begin : mon
    bit due, ep, ed;
    if (rst) begin
      exp_q.delete();
      exp_prd = '0;
      exp_drd = '0;
      chk("rst_p_rvalid", p_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_p_rdata",  p_rdata,  0);
      chk("rst_d_rdata",  d_rdata,  0);
    end else begin
      due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      ep  = due && (exp_q[0].port == 0);
      ed  = due && (exp_q[0].port == 1);
      chk("p_rvalid", p_rvalid, ep);
      chk("d_rvalid", d_rvalid, ed);
      if (ep) exp_prd = exp_q[0].data;
      if (ed) exp_drd = exp_q[0].data;
      if (due) void'(exp_q.pop_front());
      chk("p_rdata", p_rdata, exp_prd);
      chk("d_rdata", d_rdata, exp_drd);
    end
  end

  // Drive one operation on a port and hold it until granted.
  task automatic op(input int port, input bit we, input int a, input logic [DW-1:0] wd);
    bit g = 1'b0;
    if (port == 0) begin
      p_we = we; p_addr = a[AW-1:0]; p_wdata = wd; p_req = 1'b1;
    end else begin
      d_we = we; d_addr = a[AW-1:0]; d_wdata = wd; d_req = 1'b1;
    end
    for (int i = 0; i < 8 && !g; i++) begin
      @(negedge clk);
      g = (port == 0) ? p_gnt : d_gnt;
      @(posedge clk);
      #1;
    end
    if (!g) begin
      n_vec++;
      n_err++;
      $display("FAIL gnt_timeout: port %0d not granted in 8 cycles, expected grant", port);
    end
    if (port == 0) p_req = 1'b0;
    else           d_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_op(input int port);
    op(port, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset held with both ports requesting: nothing may be granted.
    rst = 1'b1;
    p_req = 1'b1; p_we = 1'b0; p_addr = 10'd7; p_wdata = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd8; d_wdata = '0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("first_tie_after_rst", {d_gnt, p_gnt}, 2'b01);
    @(posedge clk);
    #1;
    p_req = 1'b0;
    op(1, 1'b0, 8, '0);

    // Write then read the same address on consecutive cycles.
    op(0, 1'b1, 5, 32'hDEAD_BEEF);
    op(0, 1'b0, 5, '0);
    idle(2);

    // Both ports reading continuously: grants alternate.
    fork
      begin repeat (6) op(0, 1'b0, 1, '0); end
      begin repeat (6) op(1, 1'b0, 2, '0); end
    join
    idle(2);

    // Loader preload, then back-to-back pipeline reads.
    for (int i = 0; i < 4; i++) op(1, 1'b1, i, 32'h10 + i);
    for (int i = 0; i < 4; i++) op(0, 1'b0, i, '0);
    idle(3);

    // Reset in the cycle after a read grant: read is dropped at once.
    op(0, 1'b0, 3, '0);
    p_req = 1'b1;
    d_req = 1'b1;
    rst   = 1'b1;
    #1;
    chk("async_p_rvalid", p_rvalid, 0);
    chk("async_d_rvalid", d_rvalid, 0);
    chk("async_p_gnt",    p_gnt,    0);
    chk("async_d_gnt",    d_gnt,    0);
    chk("async_mem_en",   mem_en,   0);
    chk("async_p_rdata",  p_rdata,  0);
    p_req = 1'b0;
    d_req = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(3);

    // Loader hammering every cycle while the pipeline keeps requesting.
    fork
      begin repeat (100) rand_op(1); end
      begin repeat (30)  rand_op(0); end
    join
    idle(2);

    // Random traffic with random idle gaps on both ports.
    fork
      begin
        repeat (60) begin
          if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
          rand_op(0);
        end
      end
      begin
        repeat (60) begin
          if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
          rand_op(1);
        end
      end
    join
    idle(4);

    chk("rsp_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
